// File: rtl/vx_fpu_pkg.sv
// vx_fpu_pkg: shared FPU response types (flag layout, default response record).
package vx_fpu_pkg;

   localparam int unsigned FP_FLAGS_BITS = 5;

   // Widths of the default (single-lane, 1-bit tag) response record.
   localparam int unsigned FPU_TAGW      = 1;
   localparam int unsigned FPU_NUM_LANES = 1;
   localparam int unsigned FPU_RESW      = FPU_NUM_LANES * 32;

   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } fflags_t;

   typedef struct packed {
      logic [FPU_TAGW-1:0] tag;
      logic [FPU_RESW-1:0] result;
      logic                has_fflags;
      fflags_t             fflags;
   } fpu_rsp_t;

endpackage

// File: rtl/vx_fpu_rsp_fifo.sv
// vx_fpu_rsp_fifo: in-order pointer/count FIFO with a registered not-full
// flag and a registered head entry (no same-cycle bypass).
module vx_fpu_rsp_fifo #(
   parameter int unsigned DATAW = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [DATAW-1:0]         data_i,
   output logic                     ready_o,
   output logic                     valid_o,
   input  logic                     pop_i,
   output logic [DATAW-1:0]         data_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PTRW = $clog2(DEPTH);
   localparam int unsigned CNTW = PTRW + 1;

   logic [DATAW-1:0] mem_q [DEPTH];
   logic [DATAW-1:0] head_q, head_d;
   logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]  count_q, count_d;
   logic             ready_q, ready_d, valid_q, valid_d;
   logic             push, pop;

   assign push = push_i && ready_q;
   assign pop  = pop_i && valid_q;

   // Next pointers/count/flags, and which entry becomes the registered head.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      head_d   = head_q;
      if (push) wr_ptr_d = wr_ptr_q + PTRW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTRW'(1);
      count_d  = count_q + CNTW'(push) - CNTW'(pop);
      ready_d  = (count_d < CNTW'(DEPTH));
      valid_d  = (count_d != '0);
      // The entry being written becomes head when the FIFO is otherwise empty
      // after this cycle's pop; else the head advances from storage on a pop.
      if (push && (count_q == CNTW'(pop))) head_d = data_i;
      else if (pop)                        head_d = mem_q[rd_ptr_d];
   end

   // Control state; cleared asynchronously.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b1;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ready_q  <= ready_d;
         valid_q  <= valid_d;
      end
   end

   // Storage and head register; contents are don't-care while empty.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= data_i;
      head_q <= head_d;
   end

   assign ready_o = ready_q;
   assign valid_o = valid_q;
   assign data_o  = head_q;
   assign count_o = count_q;

endmodule

// File: rtl/vx_fpu_rsp_sink.sv
// vx_fpu_rsp_sink: buffers FPU unit responses, OR-reduces per-lane fflags at
// push time and presents them in order to the commit arbiter.
// Optional sticky flag accumulator: define FPU_RSP_FFLAGS_STICKY_EN.
module vx_fpu_rsp_sink
   import vx_fpu_pkg::*;
#(
   parameter int unsigned NUM_LANES = 1,
   parameter int unsigned TAGW      = 1,
   parameter int unsigned DEPTH     = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               valid_in,
   output logic                               ready_in,
   input  logic [TAGW-1:0]                    tag_in,
   input  logic [NUM_LANES*32-1:0]            result_in,
   input  logic                               has_fflags_in,
   input  logic [NUM_LANES*FP_FLAGS_BITS-1:0] fflags_in,
   output logic                               valid_out,
   input  logic                               ready_out,
   output logic [TAGW-1:0]                    tag_out,
   output logic [NUM_LANES*32-1:0]            result_out,
   output logic                               has_fflags_out,
   output logic [FP_FLAGS_BITS-1:0]           fflags_out,
   output logic [$clog2(DEPTH):0]             count,
   output logic [FP_FLAGS_BITS-1:0]           fflags_sticky,
   input  logic                               fflags_clr
);

   localparam int unsigned RESW  = NUM_LANES * 32;
   localparam int unsigned DATAW = TAGW + RESW + 1 + FP_FLAGS_BITS;

   logic [FP_FLAGS_BITS-1:0] lane_or;
   fflags_t                  stored_flags, head_flags;
   logic [DATAW-1:0]         push_data, head_data;
   logic                     pop;

   // OR-reduce lane flags so only one 5-bit vector is stored per entry.
   always_comb begin
      lane_or = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++)
         lane_or = lane_or | fflags_in[i*FP_FLAGS_BITS +: FP_FLAGS_BITS];
      stored_flags = has_fflags_in ? fflags_t'(lane_or) : '0;
   end

   assign push_data = {tag_in, result_in, has_fflags_in, stored_flags};
   assign {tag_out, result_out, has_fflags_out, head_flags} = head_data;
   assign fflags_out = head_flags;
   assign pop        = valid_out && ready_out;

   vx_fpu_rsp_fifo #(
      .DATAW (DATAW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (reset),
      .push_i  (valid_in),
      .data_i  (push_data),
      .ready_o (ready_in),
      .valid_o (valid_out),
      .pop_i   (ready_out),
      .data_o  (head_data),
      .count_o (count)
   );

`ifdef FPU_RSP_FFLAGS_STICKY_EN
   logic [FP_FLAGS_BITS-1:0] sticky_q, sticky_d;

   // Clear first, then OR in popped flags, so a same-cycle set wins.
   always_comb begin
      sticky_d = sticky_q;
      if (fflags_clr)              sticky_d = '0;
      if (pop && has_fflags_out)   sticky_d = sticky_d | fflags_out;
   end

   // Sticky register; cleared asynchronously.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sticky_q <= '0;
      else        sticky_q <= sticky_d;
   end

   assign fflags_sticky = sticky_q;
`else
   logic unused_sticky;
   assign unused_sticky = fflags_clr ^ pop;
   assign fflags_sticky = '0;
`endif

endmodule
